// File: rtl/convolutor_rom_reader_pkg.sv
// Shared types and constants for the ROM burst reader.
//   state_t    : controller states (IDLE, READ, DRAIN, DONE)
//   FIFO_DEPTH : entries in the output skid buffer (2)
//   FIFO_PTRW  : buffer pointer width
//   FIFO_CNTW  : buffer occupancy count width (holds 0..FIFO_DEPTH)
package convolutor_rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTRW  = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNTW  = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/convolutor_rom_reader_fifo.sv
// Small skid buffer for returned ROM words (FIFO_DEPTH entries).
//   clk, rst : clock, async active-high reset (clears storage and pointers)
//   push     : write wdata this cycle (accepted when not full, or when popping)
//   pop      : drop the head entry this cycle (ignored when empty)
//   wdata    : word to write
//   rdata    : head entry, valid while !empty
//   full     : all entries occupied
//   empty    : no entries occupied
//   count    : current occupancy
module convolutor_rom_reader_fifo
  import convolutor_rom_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_CNTW-1:0] count
);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [FIFO_PTRW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNTW-1:0]             cnt_q;
  logic                             do_push, do_pop;

  function automatic logic [FIFO_PTRW-1:0] ptr_inc(input logic [FIFO_PTRW-1:0] p);
    return (p == FIFO_PTRW'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTRW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FIFO_CNTW'(FIFO_DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + FIFO_CNTW'(do_push) - FIFO_CNTW'(do_pop);
    end
  end

endmodule

// File: rtl/convolutor_rom_reader.sv
// Burst reader: streams LENGTH consecutive words (address wraps modulo DEPTH)
// out of a synchronous ROM onto a valid/ready stream.
//   clk, rst     : clock, async active-high reset (aborts any burst, no done)
//   start_i      : one-cycle burst request, honoured only while idle
//   base_addr_i  : first ROM address, sampled with start_i
//   length_i     : word count, sampled with start_i, clamped to DEPTH
//   rom_addr_o   : ROM read address (registered, holds when not issuing)
//   rom_data_i   : ROM read data, valid one cycle after the address
//   data_o       : stream data (0 when valid_o is low)
//   valid_o      : data_o holds a beat; transfers when ready_i is high
//   ready_i      : consumer accepts
//   busy_o       : high from accepted start until done_o
//   done_o       : one-cycle pulse after the final beat
// Build option: define CONVOLUTOR_ROM_READER_ZEROPAD_EN to append PAD zero
// beats after the ROM data (zero-length bursts then emit just the pad).
//
// Read pipeline: an address is registered onto rom_addr_o, the ROM returns
// data one cycle later, and that word is offered straight to the stream when
// the buffer is empty, otherwise it queues behind the buffered words. This
// gives first valid two cycles after start and one beat per cycle.
module convolutor_rom_reader
  import convolutor_rom_reader_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  parameter  int PAD   = 4,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ADDRW-1:0] base_addr_i,
  input  logic [ADDRW:0]   length_i,
  output logic [ADDRW-1:0] rom_addr_o,
  input  logic [WIDTH-1:0] rom_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int LENW      = ADDRW + 1;
  localparam int RD_STAGES = 1;

  state_t               state_q, state_d;
  logic [ADDRW-1:0]     addr_q, addr_d, base_wrap;
  logic [LENW-1:0]      remain_q, remain_d, len_clamp;
  // [0]: address on rom_addr_o this cycle, [1]: its data on rom_data_i
  logic [RD_STAGES:0]   vld_pipe;
  logic                 issue, rom_vld, drained, room, done_q;
  logic                 pad_active, pad_done;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0]     fifo_rdata;
  logic [FIFO_CNTW-1:0] fifo_count, occ_next;

  assign base_wrap = (32'(base_addr_i) >= DEPTH) ? ADDRW'(32'(base_addr_i) - DEPTH)
                                                 : base_addr_i;
  assign len_clamp = (32'(length_i) > DEPTH) ? LENW'(DEPTH) : length_i;

  assign rom_vld = vld_pipe[RD_STAGES];

  // Returned word bypasses the buffer when it can go out this cycle.
  assign fifo_pop  = !fifo_empty && ready_i;
  assign fifo_push = rom_vld && !(fifo_empty && ready_i);

  // Credit check: buffer occupancy after this cycle plus the read whose data
  // lands next cycle must leave a slot for a new read.
  assign occ_next = fifo_count + FIFO_CNTW'(fifo_push) - FIFO_CNTW'(fifo_pop);
  assign room     = !fifo_full &&
                    ((occ_next + FIFO_CNTW'(vld_pipe[0])) < FIFO_CNTW'(FIFO_DEPTH));
  assign drained  = fifo_empty && (vld_pipe == '0);

  convolutor_rom_reader_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rom_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef CONVOLUTOR_ROM_READER_ZEROPAD_EN
  localparam int PADW = $clog2(PAD + 2);
  logic [PADW-1:0] pad_q;

  // Pad beats start only once every ROM word has left the reader.
  assign pad_active = (state_q == DRAIN) && drained && (pad_q != '0);
  assign pad_done   = (pad_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               pad_q <= '0;
    else if (state_q == IDLE && start_i)   pad_q <= PADW'(PAD);
    else if (pad_active && ready_i)        pad_q <= pad_q - PADW'(1);
  end
`else
  assign pad_active = 1'b0;
  assign pad_done   = 1'b1;
  // PAD has no effect in this build; only its range is meaningful.
  if (PAD < 0) begin : g_pad_range
  end
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_clamp != '0) begin
            // First address goes out straight away; no data is buffered yet.
            state_d  = READ;
            addr_d   = base_wrap;
            remain_d = len_clamp - LENW'(1);
            issue    = 1'b1;
          end else begin
`ifdef CONVOLUTOR_ROM_READER_ZEROPAD_EN
            state_d = DRAIN;
`else
            state_d = DONE;
`endif
          end
        end
      end
      READ: begin
        if (remain_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          issue    = 1'b1;
          addr_d   = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + ADDRW'(1);
          remain_d = remain_q - LENW'(1);
        end
      end
      DRAIN: begin
        if (drained && pad_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      vld_pipe <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      vld_pipe <= {vld_pipe[RD_STAGES-1:0], issue};
      done_q   <= (state_q == DONE);
    end
  end

  assign rom_addr_o = addr_q;
  assign valid_o    = !fifo_empty || rom_vld || pad_active;
  assign data_o     = !fifo_empty ? fifo_rdata : (rom_vld ? rom_data_i : '0);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule
